mod_n_pulse_counter: RTL and testbench

//   Parametrised successor to the fixed divide-by-five enable generator.
//   - Counts qualified clock cycles and emits a one-cycle `enable` pulse every DIV cycles.
//   - DIV is loadable at run time.
//   - Supports periodic or one-shot mode.
//   - Keeps a saturating count of pulses issued.
//   - Sits beside the clock/reset source and paces downstream datapath blocks.

---
 rtl/mod_n_pulse_counter.sv | 87 ++++++++
 tb/tb_mod_n_pulse_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mod_n_pulse_counter.sv
// Programmable divide-by-N enable generator with periodic/one-shot modes
// and a saturating count of the enable pulses issued since reset.
module mod_n_pulse_counter #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5,
    parameter int PCNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  div_in,
    output logic              enable,
    output logic [WIDTH-1:0]  count,
    output logic [WIDTH-1:0]  div,
    output logic              busy,
    output logic [PCNT_W-1:0] pulse_total
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    div_q, div_d;
    logic                enable_q, enable_d;
    logic [PCNT_W-1:0]   pulse_total_q, pulse_total_d;
    logic                tc;

    // div_q is never 0, so div_q - 1 cannot wrap.
    assign tc = (state_q == ST_RUN) && run && (count_q == div_q - ONE);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        div_d         = div_q;
        enable_d      = 1'b0;
        pulse_total_d = pulse_total_q;

        if (load) begin
            div_d   = (div_in == '0) ? ONE : div_in;
            count_d = '0;
            state_d = ST_RUN;
        end else if (tc) begin
            count_d  = '0;
            enable_d = 1'b1;
            if (pulse_total_q != '1) begin
                pulse_total_d = pulse_total_q + 1'b1;
            end
            if (mode) begin
                state_d = ST_DONE;
            end
        end else if ((state_q == ST_RUN) && run) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            count_q       <= '0;
            div_q         <= DIV_RST;
            enable_q      <= 1'b0;
            pulse_total_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            div_q         <= div_d;
            enable_q      <= enable_d;
            pulse_total_q <= pulse_total_d;
        end
    end

    // All outputs come straight from flops.
    assign enable      = enable_q;
    assign count       = count_q;
    assign div         = div_q;
    assign busy        = (state_q == ST_RUN);
    assign pulse_total = pulse_total_q;

endmodule

// File: tb/tb_mod_n_pulse_counter.sv
// Directed scenarios plus a random phase, checked every cycle against an
// arithmetic model (qualified-cycle tally modulo divisor) for two widths.
module tb_mod_n_pulse_counter;

    logic        clock = 1'b0;
    logic        reset, run, mode, load;
    logic [7:0]  div_in;

    logic        en_a, busy_a;
    logic [7:0]  count_a, div_a;
    logic [15:0] tot_a;
    logic        en_b, busy_b;
    logic [7:0]  count_b, div_b;
    logic [3:0]  tot_b;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_div, m_k, m_tot_a, m_tot_b;
    bit m_done, m_en;

    always #5 clock = ~clock;

    mod_n_pulse_counter #(.WIDTH(8), .DEFAULT_DIV(5), .PCNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .run(run), .mode(mode), .load(load),
        .div_in(div_in), .enable(en_a), .count(count_a), .div(div_a),
        .busy(busy_a), .pulse_total(tot_a)
    );

    mod_n_pulse_counter #(.WIDTH(8), .DEFAULT_DIV(5), .PCNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .run(run), .mode(mode), .load(load),
        .div_in(div_in), .enable(en_b), .count(count_b), .div(div_b),
        .busy(busy_b), .pulse_total(tot_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string name, input bit r, input bit ld, input bit rn,
                        input bit md, input logic [7:0] dv);
        int exp_cnt;
        reset = r; load = ld; run = rn; mode = md; div_in = dv;
        @(posedge clock);
        if (r) begin
            m_div = 5; m_k = 0; m_done = 0; m_en = 0; m_tot_a = 0; m_tot_b = 0;
        end else if (ld) begin
            m_div = (dv == 0) ? 1 : int'(dv);
            m_k = 0; m_done = 0; m_en = 0;
        end else if (!m_done && rn) begin
            m_k++;
            m_en = ((m_k % m_div) == 0);
            if (m_en) begin
                if (m_tot_a < 65535) m_tot_a++;
                if (m_tot_b < 15) m_tot_b++;
                if (md) m_done = 1;
            end
        end else begin
            m_en = 0;
        end
        exp_cnt = m_done ? 0 : (m_k % m_div);
        #1;
        chk({name, ".enable"}, 32'(en_a), 32'(m_en));
        chk({name, ".count"}, 32'(count_a), 32'(exp_cnt));
        chk({name, ".div"}, 32'(div_a), 32'(m_div));
        chk({name, ".busy"}, 32'(busy_a), 32'(!m_done));
        chk({name, ".total16"}, 32'(tot_a), 32'(m_tot_a));
        chk({name, ".total4"}, 32'(tot_b), 32'(m_tot_b));
        chk({name, ".enable4"}, 32'(en_b), 32'(m_en));
        chk({name, ".count4"}, 32'(count_b), 32'(exp_cnt));
        $display("%0t %s r=%0b ld=%0b run=%0b mode=%0b div_in=%0d -> en=%0b cnt=%0d div=%0d busy=%0b tot=%0d/%0d",
                 $time, name, r, ld, rn, md, dv, en_a, count_a, div_a, busy_a, tot_a, tot_b);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; mode = 1'b0; load = 1'b0; div_in = '0;

        // T1: reset, then periodic divide-by-5
        step("T1rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step("T1", 0, 0, 1, 0, 0);
        chk("T1.total_after15", 32'(tot_a), 32'd3);

        // T2: one-shot with div 3, idle in DONE, reload resumes
        step("T2ld", 0, 1, 1, 1, 8'd3);
        for (int i = 0; i < 13; i++) step("T2", 0, 0, 1, 1, 0);
        chk("T2.busy_done", 32'(busy_a), 32'd0);
        step("T2ld2", 0, 1, 1, 0, 8'd3);
        for (int i = 0; i < 4; i++) step("T2b", 0, 0, 1, 0, 0);

        // T3: run dropped for two cycles at count 2 delays the pulse
        step("T3ld", 0, 1, 0, 0, 8'd5);
        for (int i = 0; i < 2; i++) step("T3a", 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step("T3hold", 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("T3b", 0, 0, 1, 0, 0);

        // T5: load at count 4 suppresses the pulse; reset mid-count
        step("T5ld", 0, 1, 0, 0, 8'd5);
        for (int i = 0; i < 4; i++) step("T5a", 0, 0, 1, 0, 0);
        step("T5ldtc", 0, 1, 1, 0, 8'd5);
        chk("T5.no_pulse", 32'(en_a), 32'd0);
        for (int i = 0; i < 3; i++) step("T5b", 0, 0, 1, 0, 0);
        step("T5rst", 1, 0, 1, 0, 0);

        // T4/T6: div_in 0 stored as 1, continuous enable, 4-bit total saturates
        step("T4ld", 0, 1, 1, 0, 8'd0);
        for (int i = 0; i < 20; i++) step("T4", 0, 0, 1, 0, 0);
        chk("T6.sat4", 32'(tot_b), 32'd15);
        step("T4run0", 0, 0, 0, 0, 0);
        step("T4oneshot", 0, 0, 1, 1, 0);
        step("T4done", 0, 0, 1, 1, 0);

        // random phase
        step("Rrst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit r, ld, rn, md;
            logic [7:0] dv;
            r  = ($urandom_range(0, 79) == 0);
            ld = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 3) != 0);
            md = ($urandom_range(0, 5) == 0);
            dv = 8'($urandom_range(0, 7));
            step("R", r, ld, rn, md, dv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
